// File: rtl/fbw_pkg.sv
// Shared types and constants for the framebuffer write arbiter: parser states,
// address/pixel widths, the queued write entry and the frame checksum helper.
package fbw_pkg;

    localparam int FBW_ADDR_W = 19;
    localparam int FBW_PIX_W  = 24;
    localparam logic [7:0] FBW_SYNC_DEFAULT = 8'hA5;

    typedef enum logic [3:0] {
        PS_IDLE = 4'd0,
        PS_H_HI = 4'd1,
        PS_H_LO = 4'd2,
        PS_V_HI = 4'd3,
        PS_V_LO = 4'd4,
        PS_R    = 4'd5,
        PS_G    = 4'd6,
        PS_B    = 4'd7,
        PS_CK   = 4'd8
    } fbw_state_e;

    typedef struct packed {
        logic [FBW_ADDR_W-1:0] addr;
        logic [FBW_PIX_W-1:0]  rgb;
    } fbw_entry_t;

    localparam fbw_entry_t FBW_ENTRY_ZERO = {(FBW_ADDR_W + FBW_PIX_W){1'b0}};

    // Running XOR over the frame body bytes (H_HI..B)
    function automatic logic [7:0] fbw_ck_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Bundle of UART, scanout and framebuffer-port signals around fb_write_arbiter.
// slave = arbiter side, master = environment side.
interface fb_write_arbiter_if;
    import fbw_pkg::*;

    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [9:0]            vga_h_addr;
    logic [8:0]            vga_v_addr;
    logic                  vga_valid;
    logic [FBW_PIX_W-1:0]  vga_data;
    logic [FBW_ADDR_W-1:0] mem_addr;
    logic [FBW_PIX_W-1:0]  mem_wdata;
    logic                  mem_we;
    logic [FBW_PIX_W-1:0]  mem_rdata;
    logic [15:0]           wr_count;
    logic [7:0]            drop_count;

    modport slave (
        input  rx_data, rx_valid, vga_h_addr, vga_v_addr, vga_valid, mem_rdata,
        output rx_ready, vga_data, mem_addr, mem_wdata, mem_we, wr_count, drop_count
    );

    modport master (
        output rx_data, rx_valid, vga_h_addr, vga_v_addr, vga_valid, mem_rdata,
        input  rx_ready, vga_data, mem_addr, mem_wdata, mem_we, wr_count, drop_count
    );

endinterface

// File: rtl/fb_wr_fifo.sv
// Synchronous write queue for pending pixel writes; head is registered storage,
// so a pushed entry appears at the head on the following cycle.
module fb_wr_fifo
    import fbw_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  fbw_entry_t push_data,
    input  logic       pop,
    output fbw_entry_t head,
    output logic       full,
    output logic       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   CNT_ZERO = (PW + 1)'(1'b0);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1'b1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

    fbw_entry_t    mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign do_push_s = push && (count_r != FULL_CNT);
    assign do_pop_s  = pop && (count_r != CNT_ZERO);
    assign head      = mem_r[rd_ptr_r];
    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == CNT_ZERO);

    // Entry storage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= FBW_ENTRY_ZERO;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Parses UART frames into pixel writes and shares the framebuffer port with scanout.
// Optional FBW_CHECKSUM_EN adds a trailing XOR checksum byte to each frame.
module fb_write_arbiter
    import fbw_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter int         H_MAX      = 640,
    parameter int         V_MAX      = 480,
    parameter logic [7:0] SYNC_BYTE  = FBW_SYNC_DEFAULT
)(
    input logic               clk,
    input logic               resetn,
    fb_write_arbiter_if.slave bus
);
`ifdef FBW_CHECKSUM_EN
    localparam fbw_state_e LAST_ST = PS_CK;
`else
    localparam fbw_state_e LAST_ST = PS_B;
`endif

    fbw_state_e            state_r;
    logic [9:0]            h_r;
    logic [8:0]            v_r;
    logic [7:0]            r_r;
    logic [7:0]            g_r;
`ifdef FBW_CHECKSUM_EN
    logic [7:0]            b_r;
    logic [7:0]            ck_acc_r;
`endif
    logic                  accept_s;
    logic                  rx_ready_s;
    logic                  in_range_s;
    logic                  frame_ok_s;
    logic                  last_accept_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  pop_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    fbw_entry_t            push_entry_s;
    fbw_entry_t            head_s;
    logic [FBW_ADDR_W-1:0] mem_addr_s;
    logic [FBW_PIX_W-1:0]  mem_wdata_s;
    logic                  mem_we_s;
    logic [15:0]           wr_count_r;
    logic [7:0]            drop_count_r;

    assign accept_s      = bus.rx_valid && rx_ready_s;
    assign last_accept_s = accept_s && (state_r == LAST_ST);
    assign in_range_s    = (32'(h_r) < H_MAX) && (32'(v_r) < V_MAX);
    assign push_s        = last_accept_s && frame_ok_s;
    assign drop_s        = last_accept_s && !frame_ok_s;

    // Backpressure only on the byte that would push; full is registered in the FIFO
    always_comb begin
        if (state_r == LAST_ST) begin
            rx_ready_s = !fifo_full_s;
        end else begin
            rx_ready_s = 1'b1;
        end
    end

    // Entry assembled from captured fields plus the byte on the bus when it is B
    always_comb begin
        push_entry_s.addr = {h_r, v_r};
`ifdef FBW_CHECKSUM_EN
        push_entry_s.rgb  = {r_r, g_r, b_r};
        frame_ok_s        = in_range_s && (bus.rx_data == ck_acc_r);
`else
        push_entry_s.rgb  = {r_r, g_r, bus.rx_data};
        frame_ok_s        = in_range_s;
`endif
    end

    // Frame parser: one state per accepted byte
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= PS_IDLE;
            h_r     <= 10'd0;
            v_r     <= 9'd0;
            r_r     <= 8'd0;
            g_r     <= 8'd0;
`ifdef FBW_CHECKSUM_EN
            b_r     <= 8'd0;
`endif
        end else if (accept_s) begin
            case (state_r)
                PS_IDLE: state_r <= (bus.rx_data == SYNC_BYTE) ? PS_H_HI : PS_IDLE;
                PS_H_HI: begin h_r[9:8] <= bus.rx_data[1:0]; state_r <= PS_H_LO; end
                PS_H_LO: begin h_r[7:0] <= bus.rx_data;      state_r <= PS_V_HI; end
                PS_V_HI: begin v_r[8]   <= bus.rx_data[0];   state_r <= PS_V_LO; end
                PS_V_LO: begin v_r[7:0] <= bus.rx_data;      state_r <= PS_R;    end
                PS_R:    begin r_r      <= bus.rx_data;      state_r <= PS_G;    end
                PS_G:    begin g_r      <= bus.rx_data;      state_r <= PS_B;    end
`ifdef FBW_CHECKSUM_EN
                PS_B:    begin b_r      <= bus.rx_data;      state_r <= PS_CK;   end
`else
                PS_B:    state_r <= PS_IDLE;
`endif
                PS_CK:   state_r <= PS_IDLE;
                default: state_r <= PS_IDLE;
            endcase
        end
    end

`ifdef FBW_CHECKSUM_EN
    // Checksum accumulator, restarted by every byte seen while idle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ck_acc_r <= 8'h00;
        end else if (accept_s) begin
            if (state_r == PS_IDLE) ck_acc_r <= 8'h00;
            else                    ck_acc_r <= fbw_ck_update(ck_acc_r, bus.rx_data);
        end
    end
`endif

    fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Port mux: scanout wins, queued writes drain only in blanking
    always_comb begin
        if (bus.vga_valid) begin
            mem_addr_s  = {bus.vga_h_addr, bus.vga_v_addr};
            mem_wdata_s = 24'h000000;
            mem_we_s    = 1'b0;
            pop_s       = 1'b0;
        end else if (!fifo_empty_s) begin
            mem_addr_s  = head_s.addr;
            mem_wdata_s = head_s.rgb;
            mem_we_s    = 1'b1;
            pop_s       = 1'b1;
        end else begin
            mem_addr_s  = {bus.vga_h_addr, bus.vga_v_addr};
            mem_wdata_s = 24'h000000;
            mem_we_s    = 1'b0;
            pop_s       = 1'b0;
        end
    end

    // Saturating commit and drop counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_count_r   <= 16'd0;
            drop_count_r <= 8'd0;
        end else begin
            if (pop_s && (wr_count_r != 16'hFFFF))  wr_count_r   <= wr_count_r + 16'd1;
            if (drop_s && (drop_count_r != 8'hFF))  drop_count_r <= drop_count_r + 8'd1;
        end
    end

    assign bus.rx_ready   = rx_ready_s;
    assign bus.vga_data   = bus.mem_rdata;
    assign bus.mem_addr   = mem_addr_s;
    assign bus.mem_wdata  = mem_wdata_s;
    assign bus.mem_we     = mem_we_s;
    assign bus.wr_count   = wr_count_r;
    assign bus.drop_count = drop_count_r;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: port-mux vector table, directed
// corner sequences and randomized frames against a frame-level reference model.
module tb_fb_write_arbiter;
    import fbw_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    fb_write_arbiter_if bus();

    fb_write_arbiter #(.FIFO_DEPTH(4), .H_MAX(640), .V_MAX(480), .SYNC_BYTE(8'hA5)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit rand_vga = 1'b0;
    logic [42:0] exp_q[$];
    logic [42:0] obs_q[$];
    int exp_wr = 0;
    int exp_drop = 0;
    logic [7:0] frame_bytes [9];
    int frame_len;

    typedef struct {
        logic        vv;
        logic [9:0]  h;
        logic [8:0]  v;
        logic [23:0] rd;
        logic [18:0] exp_addr;
        logic        exp_we;
    } mux_vec_t;
    mux_vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Every committed write is logged; a write during active video is an error
    always @(negedge clk) begin
        if (resetn === 1'b1 && bus.mem_we === 1'b1) begin
            obs_q.push_back({bus.mem_addr, bus.mem_wdata});
            total++;
            if (bus.vga_valid !== 1'b0) begin
                bad++;
                $display("FAIL we_in_video: mem_we=1 with vga_valid=%b", bus.vga_valid);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        while (!done) begin
            if (rand_vga) begin
                bus.vga_valid  = ($urandom_range(0, 2) == 0);
                bus.vga_h_addr = 10'($urandom_range(0, 1023));
                bus.vga_v_addr = 9'($urandom_range(0, 511));
            end
            @(negedge clk);
            if (bus.rx_ready === 1'b1) done = 1'b1;
            @(posedge clk); #1;
            n++;
            if (!done && n > 200) begin
                total++;
                bad++;
                $display("FAIL rx_timeout: byte %0h not accepted within 200 cycles", b);
                done = 1'b1;
            end
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic build_frame(input logic [9:0] h, input logic [8:0] v, input logic [23:0] rgb,
                               input logic [5:0] jh, input logic [6:0] jv, input bit bad_ck);
        logic [7:0] ck;
        frame_bytes[0] = 8'hA5;
        frame_bytes[1] = {jh, h[9:8]};
        frame_bytes[2] = h[7:0];
        frame_bytes[3] = {jv, v[8]};
        frame_bytes[4] = v[7:0];
        frame_bytes[5] = rgb[23:16];
        frame_bytes[6] = rgb[15:8];
        frame_bytes[7] = rgb[7:0];
        ck = 8'h00;
        for (int i = 1; i < 8; i++) ck = ck ^ frame_bytes[i];
        frame_bytes[8] = bad_ck ? (ck ^ 8'h01) : ck;
`ifdef FBW_CHECKSUM_EN
        frame_len = 9;
`else
        frame_len = 8;
`endif
    endtask

    // Frame-level reference: in-range (and checksum-clean) frames queue in order
    task automatic model_frame(input logic [9:0] h, input logic [8:0] v, input logic [23:0] rgb, input bit bad_ck);
        bit ok;
        ok = (int'(h) < 640) && (int'(v) < 480);
`ifdef FBW_CHECKSUM_EN
        if (bad_ck) ok = 1'b0;
`endif
        if (ok) begin
            exp_q.push_back({h, v, rgb});
            if (exp_wr < 65535) exp_wr++;
        end else begin
            if (exp_drop < 255) exp_drop++;
        end
    endtask

    task automatic send_frame(input logic [9:0] h, input logic [8:0] v, input logic [23:0] rgb,
                              input logic [5:0] jh, input logic [6:0] jv, input bit bad_ck);
        build_frame(h, v, rgb, jh, jv, bad_ck);
        for (int i = 0; i < frame_len; i++) send_byte(frame_bytes[i]);
        model_frame(h, v, rgb, bad_ck);
    endtask

    task automatic drain(input string name);
        bit empty_seen;
        empty_seen = 1'b0;
        bus.vga_valid = 1'b0;
        for (int n = 0; n < 40 && !empty_seen; n++) begin
            @(negedge clk);
            if (bus.mem_we === 1'b0) empty_seen = 1'b1;
            @(posedge clk); #1;
        end
        if (!empty_seen) begin
            total++;
            bad++;
            $display("FAIL %s_drain: queue not empty after 40 cycles", name);
        end
    endtask

    task automatic check_writes(input string name);
        chk({name, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            chk({name, "_write"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic check_counters(input string name);
        @(negedge clk);
        chk({name, "_wr_count"}, 64'(bus.wr_count), 64'(exp_wr));
        chk({name, "_drop_count"}, 64'(bus.drop_count), 64'(exp_drop));
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 10'd3,   9'd2,   24'hABCDEF, 19'h00602, 1'b0};
        vecs[1] = '{1'b0, 10'd3,   9'd2,   24'h123456, 19'h00602, 1'b0};
        vecs[2] = '{1'b1, 10'd639, 9'd479, 24'hFFFFFF, 19'h4FFDF, 1'b0};
        vecs[3] = '{1'b1, 10'd0,   9'd0,   24'h000000, 19'h00000, 1'b0};
        vecs[4] = '{1'b0, 10'h3FF, 9'h1FF, 24'h5A5A5A, 19'h7FFFF, 1'b0};

        resetn = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        bus.vga_h_addr = 10'd0;
        bus.vga_v_addr = 9'd0;
        bus.vga_valid = 1'b0;
        bus.mem_rdata = 24'h000000;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_rx_ready", 64'(bus.rx_ready), 64'd1);
        chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
        chk("rst_wr_count", 64'(bus.wr_count), 64'd0);
        chk("rst_drop_count", 64'(bus.drop_count), 64'd0);
        @(posedge clk); #1;

        // Port mux with an empty queue
        for (int i = 0; i < 5; i++) begin
            bus.vga_valid  = vecs[i].vv;
            bus.vga_h_addr = vecs[i].h;
            bus.vga_v_addr = vecs[i].v;
            bus.mem_rdata  = vecs[i].rd;
            @(negedge clk);
            chk("mux_addr", 64'(bus.mem_addr), 64'(vecs[i].exp_addr));
            chk("mux_we", 64'(bus.mem_we), 64'(vecs[i].exp_we));
            chk("mux_vga_data", 64'(bus.vga_data), 64'(vecs[i].rd));
            @(posedge clk); #1;
        end
        bus.vga_valid = 1'b0;

        // Single frame in blanking: write one cycle after the last byte
        send_frame(10'd5, 9'd7, 24'h112233, 6'd0, 7'd0, 1'b0);
        @(negedge clk);
        chk("t1_we", 64'(bus.mem_we), 64'd1);
        chk("t1_addr", 64'(bus.mem_addr), 64'h00A07);
        chk("t1_wdata", 64'(bus.mem_wdata), 64'h112233);
        @(posedge clk); #1;
        check_counters("t1");
        chk("t1_wr_is_1", 64'(bus.wr_count), 64'd1);
        check_writes("t1");

        // Leading junk, h=640 drop, boundary-valid frame, v=480 drop
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(10'd640, 9'd1, 24'h010203, 6'd0, 7'd0, 1'b0);
        drain("t3a");
        @(negedge clk);
        chk("t3_drop_is_1", 64'(bus.drop_count), 64'd1);
        @(posedge clk); #1;
        send_frame(10'd639, 9'd479, 24'hC0FFEE, 6'd0, 7'd0, 1'b0);
        send_frame(10'd10, 9'd480, 24'h445566, 6'd0, 7'd0, 1'b0);
        drain("t3b");
        check_counters("t3");
        check_writes("t3");

        // Queue fills during active video, then drains in order
        bus.vga_valid = 1'b1;
        for (int k = 0; k < 4; k++) send_frame(10'(20 + k), 9'(30 + k), 24'(24'hA00000 + k), 6'd0, 7'd0, 1'b0);
        build_frame(10'd99, 9'd88, 24'h778899, 6'd0, 7'd0, 1'b0);
        for (int i = 0; i < frame_len - 1; i++) send_byte(frame_bytes[i]);
        bus.rx_data = frame_bytes[frame_len - 1];
        bus.rx_valid = 1'b1;
        @(negedge clk);
        chk("t2_backpressure", 64'(bus.rx_ready), 64'd0);
        @(posedge clk); #1;
        chk("t2_no_write_in_video", 64'(obs_q.size()), 64'd0);
        bus.vga_valid = 1'b0;
        send_byte(frame_bytes[frame_len - 1]);
        model_frame(10'd99, 9'd88, 24'h778899, 1'b0);
        chk("t2_early_writes", 64'(obs_q.size()), 64'd2);
        drain("t2");
        check_counters("t2");
        check_writes("t2");

        // Reset mid-frame with writes queued
        bus.vga_valid = 1'b1;
        send_frame(10'd1, 9'd1, 24'h111111, 6'd0, 7'd0, 1'b0);
        send_frame(10'd2, 9'd2, 24'h222222, 6'd0, 7'd0, 1'b0);
        build_frame(10'd3, 9'd3, 24'h333333, 6'd0, 7'd0, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(frame_bytes[i]);
        resetn = 1'b0;
        exp_q.delete();
        exp_wr = 0;
        exp_drop = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        bus.vga_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_writes("t5_flushed");
        check_counters("t5_after_reset");
        send_frame(10'd7, 9'd9, 24'hABCDEF, 6'd0, 7'd0, 1'b0);
        drain("t5");
        check_counters("t5");
        check_writes("t5");

`ifdef FBW_CHECKSUM_EN
        // Checksum good then corrupted
        send_frame(10'd12, 9'd34, 24'h5A5A5A, 6'd0, 7'd0, 1'b0);
        send_frame(10'd13, 9'd35, 24'hA5A5A5, 6'd0, 7'd0, 1'b1);
        drain("t6");
        @(negedge clk);
        chk("t6_drop_is_1", 64'(bus.drop_count), 64'd1);
        @(posedge clk); #1;
        check_counters("t6");
        check_writes("t6");
`endif

        // Randomized frames with junk high bits, gaps and random scanout activity
        rand_vga = 1'b1;
        for (int f = 0; f < 40; f++) begin
            logic [9:0] rh;
            logic [8:0] rv;
            int nj;
            nj = $urandom_range(0, 2);
            for (int j = 0; j < nj; j++) begin
                logic [7:0] jb;
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'hA5) jb = 8'h00;
                send_byte(jb);
            end
            rh = 10'($urandom_range(0, 700));
            rv = 9'($urandom_range(0, 520));
            send_frame(rh, rv, 24'($urandom), 6'($urandom_range(0, 63)), 7'($urandom_range(0, 127)),
                       ($urandom_range(0, 7) == 0));
        end
        rand_vga = 1'b0;
        drain("rand");
        check_counters("rand");
        check_writes("rand");

        // Drop counter saturates at all-ones
        for (int f = 0; f < 260; f++) send_frame(10'd700, 9'd5, 24'h0, 6'd0, 7'd0, 1'b0);
        drain("sat");
        @(negedge clk);
        chk("sat_drop_ff", 64'(bus.drop_count), 64'hFF);
        @(posedge clk); #1;
        check_counters("sat");
        check_writes("sat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
